// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: elastic two-entry (main + skid) pipeline stage with
// valid/ready on both sides and a synchronous flush. o_ready is taken from
// registered state only, so downstream i_ready never reaches it through logic.
module pipe_skid_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REG    = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_valid,
    input  logic [NUM_REG*DATA_WIDTH-1:0] i_data,
    output logic                          o_ready,
    output logic                          o_valid,
    output logic [NUM_REG*DATA_WIDTH-1:0] o_data,
    input  logic                          i_ready,
    input  logic                          i_flush,
    output logic [1:0]                    o_count
);

    localparam int W = NUM_REG * DATA_WIDTH;

    // Occupancy states; encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   main_q, main_d;
    logic [W-1:0]   skid_q, skid_d;
    logic           acc;
    logic           xfer;

    // Handshake outputs decoded purely from registered state.
    always_comb begin
        o_valid = (state_q != EMPTY);
        o_ready = (state_q != TWO);
        o_data  = main_q;
        unique case (state_q)
            EMPTY:   o_count = 2'd0;
            ONE:     o_count = 2'd1;
            TWO:     o_count = 2'd2;
            default: o_count = 2'd0;
        endcase
    end

    // Next-state and datapath loads; entries only load on an accepted word.
    always_comb begin
        // NOTE: every signal gets a hold default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        acc     = i_valid & o_ready;
        xfer    = o_valid & i_ready;

        if (i_flush) begin
            // Held words are dropped; stale main/skid are harmless because
            // o_valid drops with the state.
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (acc) begin
                        main_d  = i_data;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (acc && xfer) begin
                        main_d = i_data;
                    end else if (xfer) begin
                        state_d = EMPTY;
                    end else if (acc) begin
                        skid_d  = i_data;
                        state_d = TWO;
                    end
                end
                TWO: begin
                    // o_ready is low here, so nothing can be accepted.
                    if (xfer) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // State and entry registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the data entries are reset as well so o_data reads zero
            // during and right after reset instead of leftover contents.
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above, independent of statement order.
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage (DATA_WIDTH=16, NUM_REG=2). A small
// occupancy model plus a queue of accepted words predicts every output.
module tb_pipe_skid_stage;

    localparam int DW = 16;
    localparam int NR = 2;
    localparam int W  = DW * NR;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_valid;
    logic [W-1:0] i_data;
    logic         o_ready;
    logic         o_valid;
    logic [W-1:0] o_data;
    logic         i_ready;
    logic         i_flush;
    logic [1:0]   o_count;

    int           n_cmp = 0;
    int           n_err = 0;
    int           n_acc = 0;
    int           cnt   = 0;
    logic [W-1:0] sb[$];

    pipe_skid_stage #(.DATA_WIDTH(DW), .NUM_REG(NR)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_data  (i_data),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .o_data  (o_data),
        .i_ready (i_ready),
        .i_flush (i_flush),
        .o_count (o_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare all outputs against the model at the current (non-edge) time.
    task automatic check_outputs(input string tag);
        logic [W-1:0] exp_count;
        exp_count = W'(cnt);
        check({tag, " o_valid"}, W'(o_valid), W'(cnt != 0));
        check({tag, " o_ready"}, W'(o_ready), W'(cnt != 2));
        check({tag, " o_count"}, W'(o_count), exp_count);
        if (cnt != 0) check({tag, " o_data"}, o_data, sb[0]);
    endtask

    // One clock cycle: drive, check at negedge (incl. i_ready independence),
    // take the edge, update the model.
    task automatic step(input string tag, input logic v, input logic [W-1:0] d,
                        input logic r, input logic f);
        logic mv;
        logic mr;
        i_valid = v;
        i_data  = d;
        i_ready = r;
        i_flush = f;
        @(negedge clk);
        check_outputs(tag);
        i_ready = ~r;
        #1;
        check({tag, " o_ready vs i_ready"}, W'(o_ready), W'(cnt != 2));
        i_ready = r;
        @(posedge clk);
        mv = (cnt != 0);
        mr = (cnt != 2);
        if (f) begin
            sb.delete();
            cnt = 0;
        end else begin
            if (mv && r) begin
                void'(sb.pop_front());
                cnt--;
            end
            if (v && mr) begin
                sb.push_back(d);
                cnt++;
                n_acc++;
            end
        end
        #1;
    endtask

    initial begin
        int cyc;
        rst     = 1'b1;
        i_valid = 1'b0;
        i_data  = '0;
        i_ready = 1'b0;
        i_flush = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset o_valid", W'(o_valid), '0);
        check("reset o_ready", W'(o_ready), W'(1));
        check("reset o_count", W'(o_count), '0);
        check("reset o_data", o_data, '0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1. Streaming at full rate
        for (int k = 1; k <= 4; k++) step("stream", 1'b1, W'(k), 1'b1, 1'b0);
        step("stream tail", 1'b0, '0, 1'b1, 1'b0);
        step("stream idle", 1'b0, '0, 1'b1, 1'b0);

        // 2. Backpressure into TWO, X offered while full, then drain
        step("bp push A", 1'b1, W'(32'hA5), 1'b0, 1'b0);
        step("bp push B", 1'b1, W'(32'h5A), 1'b0, 1'b0);
        step("bp full offer", 1'b1, 'x, 1'b0, 1'b0);
        step("bp drain A", 1'b0, '0, 1'b1, 1'b0);
        step("bp drain B", 1'b0, '0, 1'b1, 1'b0);
        step("bp empty", 1'b0, '0, 1'b1, 1'b0);

        // 3. Flush in TWO with a word offered, then flush in ONE with acc
        step("fl fill1", 1'b1, W'(32'h11), 1'b0, 1'b0);
        step("fl fill2", 1'b1, W'(32'h22), 1'b0, 1'b0);
        step("fl two", 1'b1, W'(32'h77), 1'b0, 1'b1);
        check("flush no 77", W'(o_data == W'(32'h77)), '0);
        step("fl after", 1'b1, W'(32'h33), 1'b0, 1'b0);
        step("fl one", 1'b1, W'(32'h77), 1'b1, 1'b1);
        check("flush one no 77", W'(o_data == W'(32'h77)), '0);
        step("fl after2", 1'b0, '0, 1'b1, 1'b0);

        // 4. Asynchronous reset between edges while in TWO
        step("rs fill1", 1'b1, W'(32'hC1), 1'b0, 1'b0);
        step("rs fill2", 1'b1, W'(32'hC2), 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("async rst o_valid", W'(o_valid), '0);
        check("async rst o_ready", W'(o_ready), W'(1));
        check("async rst o_count", W'(o_count), '0);
        check("async rst o_data", o_data, '0);
        sb.delete();
        cnt = 0;
        #1;
        rst = 1'b0;
        step("rs after", 1'b0, '0, 1'b1, 1'b0);

        // 6. Stall hold in ONE with X on the idle data bus
        step("stall load", 1'b1, W'(32'h1234_5678), 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) step("stall hold", 1'b0, 'x, 1'b0, 1'b0);
        step("stall drain", 1'b0, '0, 1'b1, 1'b0);

        // 5. Random valid/ready at 50%, 10k accepted words
        n_acc = 0;
        cyc   = 0;
        while (n_acc < 10000 && cyc < 60000) begin
            step("rand", 1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)), 1'b0);
            cyc++;
        end
        check("rand words accepted", W'(n_acc >= 10000), W'(1));
        cyc = 0;
        while (cnt != 0 && cyc < 10) begin
            step("rand drain", 1'b0, '0, 1'b1, 1'b0);
            cyc++;
        end
        check("rand scoreboard empty", W'(sb.size()), '0);
        step("final idle", 1'b0, '0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
